// File: rtl/tag_lookup_if.sv
// Tag lookup controller bus bundle: PE request/response, memory miss
// path and both tag-RAM ports. master = controller side.
interface tag_lookup_if #(
  parameter int TAG_CNT   = 18,
  parameter int BLOCK_CNT = 6,
  parameter int SET_CNT   = 2,
  parameter int DOSA      = 4
);
  logic                           req_valid;
  logic                           req_ready;
  logic [TAG_CNT+BLOCK_CNT-1:0]   req_addr;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic                           rsp_hit;
  logic [SET_CNT-1:0]             rsp_set;
  logic                           miss_req_valid;
  logic                           miss_req_ready;
  logic [TAG_CNT+BLOCK_CNT-1:0]   miss_req_addr;
  logic                           fill_valid;
  logic                           fill_ready;
  logic                           evict_valid;
  logic [TAG_CNT-1:0]             evict_tag;
  logic [BLOCK_CNT-1:0]           evict_index;
  logic [SET_CNT-1:0]             evict_set;
  logic                           pe_en;
  logic [BLOCK_CNT-1:0]           index_pe;
  logic [DOSA*(TAG_CNT+1)-1:0]    tag_x;
  logic                           mem_en;
  logic [SET_CNT-1:0]             set_repl;
  logic [BLOCK_CNT-1:0]           index_mem;
  logic [TAG_CNT-1:0]             tag_upd;
  logic [TAG_CNT:0]               tag_repl_valid;

  modport master (
    input  req_valid, req_addr, rsp_ready, miss_req_ready,
    input  fill_valid, tag_x, tag_repl_valid,
    output req_ready, rsp_valid, rsp_hit, rsp_set,
    output miss_req_valid, miss_req_addr, fill_ready,
    output evict_valid, evict_tag, evict_index, evict_set,
    output pe_en, index_pe, mem_en, set_repl, index_mem, tag_upd
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, miss_req_ready,
    output fill_valid, tag_x, tag_repl_valid,
    input  req_ready, rsp_valid, rsp_hit, rsp_set,
    input  miss_req_valid, miss_req_addr, fill_ready,
    input  evict_valid, evict_tag, evict_index, evict_set,
    input  pe_en, index_pe, mem_en, set_repl, index_mem, tag_upd
  );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// Tag-RAM initiator: lookup, compare, miss fill with round-robin
// replacement, tag update and eviction report.
module tag_lookup_ctrl #(
  parameter int TAG_CNT   = 18,
  parameter int BLOCK_CNT = 6,
  parameter int SET_CNT   = 2,
  parameter int DOSA      = 4
) (
  input logic          clk,
  input logic          rst,
  tag_lookup_if.master bus
);
  localparam int W = TAG_CNT + BLOCK_CNT;
  localparam int E = TAG_CNT + 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, MISS_REQ,
    WAIT_FILL, UPDATE, EVICT_CHK, RESP
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         addr_q, addr_d;
  logic [SET_CNT-1:0]   victim_q, victim_d;
  logic                 from_rr_q, from_rr_d;
  logic                 hit_q, hit_d;
  logic [SET_CNT-1:0]   set_q, set_d;
  logic [SET_CNT-1:0]   rr_q, rr_d;

  logic [TAG_CNT-1:0]   tag_q;
  logic [BLOCK_CNT-1:0] idx_q;
  logic [E-1:0]         ent;
  logic                 hit_any, inv_any;
  logic [SET_CNT-1:0]   hit_set, inv_set;

  assign tag_q = addr_q[W-1:BLOCK_CNT];
  assign idx_q = addr_q[BLOCK_CNT-1:0];

  // Descending scan so the lowest matching / invalid way wins
  always_comb begin
    ent     = '0;
    hit_any = 1'b0;
    hit_set = '0;
    inv_any = 1'b0;
    inv_set = '0;
    for (int k = DOSA - 1; k >= 0; k--) begin
      ent = bus.tag_x[k*E +: E];
      if (ent[TAG_CNT] && ent[TAG_CNT-1:0] == tag_q) begin
        hit_any = 1'b1;
        hit_set = SET_CNT'(k);
      end
      if (!ent[TAG_CNT]) begin
        inv_any = 1'b1;
        inv_set = SET_CNT'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    from_rr_d = from_rr_q;
    hit_d     = hit_q;
    set_d     = set_q;
    rr_d      = rr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        if (hit_any) begin
          hit_d   = 1'b1;
          set_d   = hit_set;
          state_d = RESP;
        end else begin
          hit_d     = 1'b0;
          victim_d  = inv_any ? inv_set : rr_q;
          set_d     = inv_any ? inv_set : rr_q;
          from_rr_d = !inv_any;
          state_d   = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (bus.miss_req_ready) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (bus.fill_valid) state_d = UPDATE;
      end
      UPDATE: begin
        if (from_rr_q) rr_d = rr_q + SET_CNT'(1);
        state_d = EVICT_CHK;
      end
      EVICT_CHK: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      victim_q  <= '0;
      from_rr_q <= 1'b0;
      hit_q     <= 1'b0;
      set_q     <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      victim_q  <= victim_d;
      from_rr_q <= from_rr_d;
      hit_q     <= hit_d;
      set_q     <= set_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_hit        = 1'b0;
    bus.rsp_set        = '0;
    bus.miss_req_valid = 1'b0;
    bus.miss_req_addr  = '0;
    bus.fill_ready     = 1'b0;
    bus.evict_valid    = 1'b0;
    bus.evict_tag      = '0;
    bus.evict_index    = '0;
    bus.evict_set      = '0;
    bus.pe_en          = 1'b0;
    bus.index_pe       = '0;
    bus.mem_en         = 1'b0;
    bus.set_repl       = '0;
    bus.index_mem      = '0;
    bus.tag_upd        = '0;
    unique case (state_q)
      IDLE: bus.req_ready = !rst;
      LOOKUP: begin
        bus.pe_en    = 1'b1;
        bus.index_pe = idx_q;
      end
      MISS_REQ: begin
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = addr_q;
      end
      WAIT_FILL: bus.fill_ready = 1'b1;
      UPDATE: begin
        bus.mem_en    = 1'b1;
        bus.set_repl  = victim_q;
        bus.index_mem = idx_q;
        bus.tag_upd   = tag_q;
      end
      EVICT_CHK: begin
        if (bus.tag_repl_valid[TAG_CNT]) begin
          bus.evict_valid = 1'b1;
          bus.evict_tag   = bus.tag_repl_valid[TAG_CNT-1:0];
          bus.evict_index = idx_q;
          bus.evict_set   = victim_q;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = hit_q;
        bus.rsp_set   = set_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with a registered-read tag-RAM
// partner model and a cycle-stamped output monitor.
module tb_tag_lookup_ctrl;
  localparam int TC = 8;
  localparam int BC = 4;
  localparam int SC = 2;
  localparam int DS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_lookup_if #(.TAG_CNT(TC), .BLOCK_CNT(BC), .SET_CNT(SC), .DOSA(DS)) bus ();

  tag_lookup_ctrl #(.TAG_CNT(TC), .BLOCK_CNT(BC), .SET_CNT(SC), .DOSA(DS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic        rsp_ready = 1'b0;
  logic        miss_req_ready = 1'b0;
  logic        fill_valid = 1'b0;
  logic [35:0] tag_x_r = '0;
  logic [8:0]  tag_repl_r = '0;

  assign bus.req_valid      = req_valid;
  assign bus.req_addr       = req_addr;
  assign bus.rsp_ready      = rsp_ready;
  assign bus.miss_req_ready = miss_req_ready;
  assign bus.fill_valid     = fill_valid;
  assign bus.tag_x          = tag_x_r;
  assign bus.tag_repl_valid = tag_repl_r;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  // Tag RAM: registered reads on both ports, update forces valid
  logic [8:0] ram [16][4];
  always @(posedge clk) begin
    if (bus.pe_en)
      for (int k = 0; k < 4; k++) tag_x_r[k*9 +: 9] <= ram[bus.index_pe][k];
    if (bus.mem_en) begin
      tag_repl_r <= ram[bus.index_mem][bus.set_repl];
      ram[bus.index_mem][bus.set_repl] = {1'b1, bus.tag_upd};
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  int pe_cnt = 0, pe_cyc = -1, mem_cnt = 0, mem_cyc = -1;
  int ev_cnt = 0, mq_cnt = 0, rsp_cnt = 0, both_cnt = 0;
  logic [3:0]  pe_idx = '0, mem_idx = '0, ev_idx = '0;
  logic [1:0]  mem_set = '0, ev_set = '0;
  logic [7:0]  mem_tag = '0, ev_tag = '0;
  logic [11:0] mq_addr = '0;

  always @(negedge clk) begin
    if (bus.pe_en) begin pe_cnt++; pe_cyc = cyc; pe_idx = bus.index_pe; end
    if (bus.mem_en) begin
      mem_cnt++; mem_cyc = cyc;
      mem_set = bus.set_repl; mem_idx = bus.index_mem; mem_tag = bus.tag_upd;
    end
    if (bus.evict_valid) begin
      ev_cnt++; ev_tag = bus.evict_tag; ev_idx = bus.evict_index; ev_set = bus.evict_set;
    end
    if (bus.miss_req_valid) begin mq_cnt++; mq_addr = bus.miss_req_addr; end
    if (bus.rsp_valid) rsp_cnt++;
    if (bus.pe_en && bus.mem_en) both_cnt++;
  end

  logic any_out;
  assign any_out = |{bus.rsp_valid, bus.rsp_hit, bus.rsp_set, bus.miss_req_valid,
                     bus.miss_req_addr, bus.fill_ready, bus.evict_valid, bus.evict_tag,
                     bus.evict_index, bus.evict_set, bus.pe_en, bus.index_pe,
                     bus.mem_en, bus.set_repl, bus.index_mem, bus.tag_upd};

  task automatic run_req(input logic [11:0] addr, input int mw, input int fw, input int rw,
                         output int a_cyc, output int r_cyc, output logic hit,
                         output logic [1:0] set, output logic stable, output logic tmo);
    int mc, fc, rc;
    logic seen, done;
    mc = 0; fc = 0; rc = 0; seen = 1'b0; done = 1'b0;
    stable = 1'b1; tmo = 1'b0; r_cyc = -1; hit = 1'b0; set = '0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; a_cyc = cyc;
    if (bus.req_ready !== 1'b1) stable = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0; miss_req_ready = 1'b0; fill_valid = 1'b0; rsp_ready = 1'b0;
      if (bus.req_ready !== 1'b0) stable = 1'b0;
      if (bus.miss_req_valid) begin
        if (bus.miss_req_addr !== addr) stable = 1'b0;
        if (mc >= mw) miss_req_ready = 1'b1; else mc++;
      end
      if (bus.fill_ready) begin
        if (fc >= fw) fill_valid = 1'b1; else fc++;
      end
      if (bus.rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; r_cyc = cyc; hit = bus.rsp_hit; set = bus.rsp_set;
        end else if (bus.rsp_hit !== hit || bus.rsp_set !== set) stable = 1'b0;
        if (rc >= rw) begin rsp_ready = 1'b1; done = 1'b1; end else rc++;
      end
    end
    if (!done) tmo = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if (any_out !== 1'b0 || bus.req_ready !== 1'b0) begin
      $display("FAIL reset_hold: outs=%b req_ready=%b want 0/0", any_out, bus.req_ready); errs++;
    end
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); errs++;
    end
    vec++;
    if (any_out !== 1'b0) begin
      $display("FAIL reset_outs: got %b want 0", any_out); errs++;
    end
  endtask

  task automatic test_hit();
    int a, r, mq0;
    logic h, st, to;
    logic [1:0] s;
    ram[5][0] = {1'b1, 8'hA2}; ram[5][1] = {1'b0, 8'hA3};
    ram[5][2] = {1'b1, 8'hA3}; ram[5][3] = {1'b1, 8'h13};
    mq0 = mq_cnt;
    run_req(12'hA35, 0, 0, 0, a, r, h, s, st, to);
    vec++;
    if (to || !st) begin $display("FAIL hit_flow: tmo=%b stable=%b want 0/1", to, st); errs++; end
    vec++;
    if (pe_cyc !== a + 1 || pe_idx !== 4'd5) begin
      $display("FAIL hit_pe: cyc=%0d idx=%0d want %0d/5", pe_cyc, pe_idx, a + 1); errs++;
    end
    vec++;
    if (r !== a + 3 || h !== 1'b1 || s !== 2'd2) begin
      $display("FAIL hit_rsp: cyc=%0d hit=%b set=%0d want %0d/1/2", r, h, s, a + 3); errs++;
    end
    vec++;
    if (mq_cnt !== mq0 || bus.req_ready !== 1'b1) begin
      $display("FAIL hit_nomiss: mq=%0d rdy=%b want %0d/1", mq_cnt, bus.req_ready, mq0); errs++;
    end
  endtask

  task automatic test_miss_invalid();
    int a, r, ev0, mq0;
    logic h, st, to;
    logic [1:0] s;
    ram[3][0] = {1'b1, 8'h11}; ram[3][1] = '0; ram[3][2] = '0; ram[3][3] = '0;
    ev0 = ev_cnt; mq0 = mq_cnt;
    run_req(12'h223, 0, 0, 0, a, r, h, s, st, to);
    vec++;
    if (to || !st || mq_cnt !== mq0 + 1 || mq_addr !== 12'h223) begin
      $display("FAIL miss_req: tmo=%b stable=%b n=%0d addr=%h want 0/1/1/223",
               to, st, mq_cnt - mq0, mq_addr); errs++;
    end
    vec++;
    if (mem_cyc !== a + 5 || mem_set !== 2'd1 || mem_idx !== 4'd3 || mem_tag !== 8'h22) begin
      $display("FAIL miss_upd: cyc=%0d set=%0d idx=%0d tag=%h want %0d/1/3/22",
               mem_cyc, mem_set, mem_idx, mem_tag, a + 5); errs++;
    end
    vec++;
    if (ev_cnt !== ev0) begin $display("FAIL miss_noevict: got %0d want %0d", ev_cnt, ev0); errs++; end
    vec++;
    if (r !== a + 7 || h !== 1'b0 || s !== 2'd1) begin
      $display("FAIL miss_rsp: cyc=%0d hit=%b set=%0d want %0d/0/1", r, h, s, a + 7); errs++;
    end
  endtask

  task automatic test_round_robin();
    int a, r, ev0;
    logic h, st, to;
    logic [1:0] s;
    for (int k = 0; k < 4; k++) ram[7][k] = {1'b1, 8'(k + 1)};
    ev0 = ev_cnt;
    run_req(12'h557, 0, 0, 0, a, r, h, s, st, to);
    vec++;
    if (to || ev_cnt !== ev0 + 1 || ev_tag !== 8'h01 || ev_idx !== 4'd7 || ev_set !== 2'd0) begin
      $display("FAIL rr_evict0: n=%0d tag=%h idx=%0d set=%0d want 1/01/7/0",
               ev_cnt - ev0, ev_tag, ev_idx, ev_set); errs++;
    end
    vec++;
    if (mem_set !== 2'd0 || s !== 2'd0 || h !== 1'b0) begin
      $display("FAIL rr_victim0: upd=%0d rsp=%0d hit=%b want 0/0/0", mem_set, s, h); errs++;
    end
    run_req(12'h667, 0, 0, 0, a, r, h, s, st, to);
    vec++;
    if (to || ev_cnt !== ev0 + 2 || ev_tag !== 8'h02 || ev_idx !== 4'd7 || ev_set !== 2'd1) begin
      $display("FAIL rr_evict1: n=%0d tag=%h idx=%0d set=%0d want 2/02/7/1",
               ev_cnt - ev0, ev_tag, ev_idx, ev_set); errs++;
    end
    vec++;
    if (mem_set !== 2'd1 || mem_tag !== 8'h66 || s !== 2'd1) begin
      $display("FAIL rr_victim1: upd=%0d tag=%h rsp=%0d want 1/66/1", mem_set, mem_tag, s); errs++;
    end
  endtask

  task automatic test_backpressure();
    int a, r, mq0, rs0, ev0;
    logic h, st, to;
    logic [1:0] s;
    for (int k = 0; k < 4; k++) ram[9][k] = '0;
    mq0 = mq_cnt; rs0 = rsp_cnt; ev0 = ev_cnt;
    run_req(12'h7B9, 5, 10, 3, a, r, h, s, st, to);
    vec++;
    if (to || !st) begin $display("FAIL bp_stable: tmo=%b stable=%b want 0/1", to, st); errs++; end
    vec++;
    if (mq_cnt - mq0 !== 6 || rsp_cnt - rs0 !== 4) begin
      $display("FAIL bp_hold: mq=%0d rsp=%0d want 6/4", mq_cnt - mq0, rsp_cnt - rs0); errs++;
    end
    vec++;
    if (r !== a + 22 || h !== 1'b0 || s !== 2'd0 || ev_cnt !== ev0) begin
      $display("FAIL bp_rsp: cyc=%0d hit=%b set=%0d ev=%0d want %0d/0/0/0",
               r, h, s, ev_cnt - ev0, a + 22); errs++;
    end
    vec++;
    if (bus.req_ready !== 1'b1) begin $display("FAIL bp_ready: got %b want 1", bus.req_ready); errs++; end
  endtask

  task automatic test_reset_wait_fill();
    int m0, r0;
    logic got;
    for (int k = 0; k < 4; k++) ram[10][k] = '0;
    got = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 12'h3DA;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      miss_req_ready = bus.miss_req_valid;
      if (bus.fill_ready) got = 1'b1;
    end
    vec++;
    if (!got) begin $display("FAIL rstwf_reach: fill_ready=0 want 1"); errs++; end
    miss_req_ready = 1'b0; rst = 1'b1;
    m0 = mem_cnt; r0 = rsp_cnt;
    @(negedge clk);
    vec++;
    if (any_out !== 1'b0 || bus.req_ready !== 1'b0) begin
      $display("FAIL rstwf_outs: outs=%b rdy=%b want 0/0", any_out, bus.req_ready); errs++;
    end
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 1'b1) begin $display("FAIL rstwf_ready: got %b want 1", bus.req_ready); errs++; end
    fill_valid = 1'b1;
    repeat (5) @(negedge clk);
    fill_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (mem_cnt !== m0 || rsp_cnt !== r0 || any_out !== 1'b0) begin
      $display("FAIL rstwf_drop: mem=%0d rsp=%0d outs=%b want 0/0/0",
               mem_cnt - m0, rsp_cnt - r0, any_out); errs++;
    end
  endtask

  task automatic test_multi_match();
    int a, r;
    logic h, st, to;
    logic [1:0] s;
    ram[2][0] = {1'b1, 8'h4D}; ram[2][1] = {1'b1, 8'h4C};
    ram[2][2] = {1'b0, 8'h4C}; ram[2][3] = {1'b1, 8'h4C};
    run_req(12'h4C2, 0, 0, 0, a, r, h, s, st, to);
    vec++;
    if (to || r !== a + 3 || h !== 1'b1 || s !== 2'd1) begin
      $display("FAIL multi_match: tmo=%b cyc=%0d hit=%b set=%0d want 0/%0d/1/1",
               to, r, h, s, a + 3); errs++;
    end
    vec++;
    if (both_cnt !== 0) begin $display("FAIL port_excl: got %0d want 0", both_cnt); errs++; end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) ram[i][k] = '0;
    test_reset();
    test_hit();
    test_miss_invalid();
    test_round_robin();
    test_backpressure();
    test_reset_wait_fill();
    test_multi_match();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
